// File: rtl/seven_seg_scan_driver_if.sv
// Bus bundle between the value producer (data_mem/keypad side) and the
// seven-segment scan driver. The master drives value/load/mode/blank_lz;
// the slave (driver) returns busy and the tube pin signals.
interface seven_seg_scan_driver_if #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned DATA_W = 32
) ();

   logic [DATA_W-1:0] value;
   logic              load;
   logic [1:0]        mode;
   logic              blank_lz;
   logic              busy;
   logic [7:0]        seg_tube;
   logic [DIGITS-1:0] seg_enable;

   modport master (
      output value, load, mode, blank_lz,
      input  busy, seg_tube, seg_enable
   );

   modport slave (
      input  value, load, mode, blank_lz,
      output busy, seg_tube, seg_enable
   );

endinterface

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed common-anode seven-segment driver. Renders a captured value in
// decimal (sequential double-dabble), hex, per-bit binary or blank, with
// optional leading-zero blanking, and scans DIGITS digits (digit 0 rightmost).
// Optional feature macro: SEG_SIGNED_EN (decimal mode treats value as two's
// complement and shows a leading '-').
module seven_seg_scan_driver #(
   parameter int unsigned DIGITS   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned SCAN_DIV = 1
) (
   input logic                    clk_tube,
   input logic                    rst_n,
   seven_seg_scan_driver_if.slave bus
);

   localparam int unsigned IdxW = $clog2(DIGITS);
   localparam int unsigned PscW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DATA_W);
   localparam int unsigned BcdW = 4 * DIGITS;
   localparam int unsigned ExtW = (DATA_W > BcdW) ? DATA_W : BcdW;

   localparam logic [7:0] GlyphBlank = 8'hFF;
   localparam logic [7:0] GlyphDash  = 8'hBF;

   typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   cap_q, cap_d;
   logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj;
   logic                ovf_q, ovf_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                blz_q, blz_d;
`ifdef SEG_SIGNED_EN
   logic                neg_q, neg_d;
`endif
   logic [7:0]          disp_q   [DIGITS];
   logic [7:0]          disp_new [DIGITS];
   logic                disp_wr;
   logic [3:0]          nib      [DIGITS];
   logic [ExtW-1:0]     val_ext;
   logic                use_blz;
   int                  top;
   logic [PscW-1:0]     psc_q;
   logic [IdxW-1:0]     idx_q, idx_n;
   logic [7:0]          seg_q;
   logic [DIGITS-1:0]   en_q;

   // Active-low glyphs, bit 7 = dp (always off).
   function automatic logic [7:0] seg_lut(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'h0: g = 8'hC0;  4'h1: g = 8'hF9;  4'h2: g = 8'hA4;  4'h3: g = 8'hB0;
         4'h4: g = 8'h99;  4'h5: g = 8'h92;  4'h6: g = 8'h82;  4'h7: g = 8'hF8;
         4'h8: g = 8'h80;  4'h9: g = 8'h90;  4'hA: g = 8'h88;  4'hB: g = 8'h83;
         4'hC: g = 8'hC6;  4'hD: g = 8'hA1;  4'hE: g = 8'h86;  default: g = 8'h8E;
      endcase
      return g;
   endfunction

   assign bus.busy       = (state_q != StIdle);
   assign bus.seg_tube   = seg_q;
   assign bus.seg_enable = en_q;
   assign val_ext        = ExtW'(bus.value);

   // Double-dabble correction: +3 on every nibble >= 5 before the shift.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // FSM next state and conversion datapath.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      blz_d   = blz_q;
`ifdef SEG_SIGNED_EN
      neg_d   = neg_q;
`endif
      disp_wr = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.load) begin
               if (bus.mode == 2'b00) begin
`ifdef SEG_SIGNED_EN
                  neg_d = bus.value[DATA_W-1];
                  cap_d = bus.value[DATA_W-1] ? (~bus.value) + DATA_W'(1) : bus.value;
`else
                  cap_d = bus.value;
`endif
                  bcd_d   = '0;
                  ovf_d   = 1'b0;
                  cnt_d   = '0;
                  blz_d   = bus.blank_lz;
                  state_d = StConv;
               end else begin
                  disp_wr = 1'b1;
               end
            end
         end
         StConv: begin
            bcd_d = {bcd_adj[BcdW-2:0], cap_q[DATA_W-1]};
            ovf_d = ovf_q | bcd_adj[BcdW-1];
            cap_d = cap_q << 1;
            if (cnt_q == CntW'(DATA_W - 1)) state_d = StCommit;
            else cnt_d = cnt_q + CntW'(1);
         end
         StCommit: begin
            disp_wr = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Glyphs to write: from the BCD result in COMMIT, else straight from the bus.
   always_comb begin
      use_blz = (state_q == StCommit) ? blz_q : bus.blank_lz;
      top     = 0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         nib[i] = (state_q == StCommit) ? bcd_q[4*i +: 4] : val_ext[4*i +: 4];
         if (nib[i] != 4'd0) top = i;
      end
      for (int i = 0; i < int'(DIGITS); i++) begin
         disp_new[i] = (use_blz && i > top) ? GlyphBlank : seg_lut(nib[i]);
      end
      if (state_q == StCommit) begin
`ifdef SEG_SIGNED_EN
         // Sign goes just left of the highest shown digit; no room means overflow.
         if (neg_q) begin
            if (!use_blz || top >= int'(DIGITS) - 1) begin
               for (int i = 0; i < int'(DIGITS); i++) disp_new[i] = GlyphDash;
            end else begin
               disp_new[top+1] = GlyphDash;
            end
         end
`endif
         if (ovf_q) begin
            for (int i = 0; i < int'(DIGITS); i++) disp_new[i] = GlyphDash;
         end
      end else begin
         case (bus.mode)
            2'b01: ;
            2'b10: begin
               for (int i = 0; i < int'(DIGITS); i++) begin
                  disp_new[i] = (i < int'(DATA_W)) ? seg_lut({3'b000, val_ext[i]}) : GlyphBlank;
               end
            end
            default: begin
               for (int i = 0; i < int'(DIGITS); i++) disp_new[i] = GlyphBlank;
            end
         endcase
      end
   end

   // FSM and conversion state registers.
   always_ff @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cap_q   <= '0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         blz_q   <= 1'b0;
`ifdef SEG_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         blz_q   <= blz_d;
`ifdef SEG_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   // Display buffer; the old content stays visible until a write.
   always_ff @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DIGITS); i++) disp_q[i] <= GlyphBlank;
      end else if (disp_wr) begin
         for (int i = 0; i < int'(DIGITS); i++) disp_q[i] <= disp_new[i];
      end
   end

   assign idx_n = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + IdxW'(1);

   // Scan: segments and enable change on the same edge so digits never ghost.
   always_ff @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) begin
         psc_q <= '0;
         idx_q <= '0;
         seg_q <= GlyphBlank;
         en_q  <= '1;
      end else if (psc_q == PscW'(SCAN_DIV - 1)) begin
         psc_q <= '0;
         idx_q <= idx_n;
         seg_q <= disp_q[idx_n];
         en_q  <= (disp_q[idx_n] == GlyphBlank) ? '1 : ~(DIGITS'(1) << idx_n);
      end else begin
         psc_q <= psc_q + PscW'(1);
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (DIGITS=8, DATA_W=32,
// SCAN_DIV=4): table vectors, corner-case sequences and random loads
// checked against a digit-arithmetic reference model.
module tb_seven_seg_scan_driver;

   localparam int unsigned DIGITS   = 8;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned SCAN_DIV = 4;

   logic clk_tube = 1'b0;
   logic rst_n    = 1'b0;
   int   ncyc;
   int   tests    = 0;
   int   failed   = 0;

   seven_seg_scan_driver_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

   seven_seg_scan_driver #(
      .DIGITS  (DIGITS),
      .DATA_W  (DATA_W),
      .SCAN_DIV(SCAN_DIV)
   ) dut (
      .clk_tube(clk_tube),
      .rst_n   (rst_n),
      .bus     (bus)
   );

   always #5 clk_tube = ~clk_tube;

   // Clock edges since reset release; sets the expected scan position.
   always @(posedge clk_tube or negedge rst_n) begin
      if (!rst_n) ncyc <= 0;
      else        ncyc <= ncyc + 1;
   end

   typedef struct {
      logic [31:0] value;
      logic [1:0]  mode;
      logic        blz;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [10];

   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  10: return 8'h88; 11: return 8'h83;
         12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; default: return 8'h8E;
      endcase
   endfunction

   // Reference: digits from division/shift, then blanking and sign rules.
   function automatic logic [63:0] model(input logic [31:0] v, input logic [1:0] m,
                                         input logic blz);
      logic [63:0]     r;
      longint unsigned mag;
      int              dig [8];
      int              hi;
      bit              neg;
      r   = {8{8'hFF}};
      neg = 1'b0;
      hi  = 0;
      if (m == 2'b10) begin
         for (int i = 0; i < 8; i++) r[8*i +: 8] = glyph(int'(v[i]));
      end else if (m != 2'b11) begin
         mag = longint'(v);
`ifdef SEG_SIGNED_EN
         if (m == 2'b00 && v[31]) begin
            neg = 1'b1;
            mag = 64'h1_0000_0000 - longint'(v);
         end
`endif
         for (int i = 0; i < 8; i++) begin
            if (m == 2'b00) begin
               dig[i] = int'(mag % 10);
               mag    = mag / 10;
            end else begin
               dig[i] = int'((v >> (4 * i)) & 32'hF);
            end
            if (dig[i] != 0) hi = i;
         end
         for (int i = 0; i < 8; i++) r[8*i +: 8] = (blz && i > hi) ? 8'hFF : glyph(dig[i]);
         if (neg) begin
            if (!blz || hi >= 7) r = {8{8'hBF}};
            else r[8*(hi+1) +: 8] = 8'hBF;
         end
         if (m == 2'b00 && mag != 0) r = {8{8'hBF}};
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   // Sample the scanned outputs each cycle against the expected glyph set.
   task automatic sample_disp(input string name, input logic [63:0] exp, input int ncycles);
      int         n;
      int         idx;
      logic [7:0] eg;
      logic [7:0] ee;
      for (int c = 0; c < ncycles; c++) begin
         @(negedge clk_tube);
         n = ncyc;
         if (n >= int'(SCAN_DIV)) begin
            idx = (n / int'(SCAN_DIV)) % int'(DIGITS);
            eg  = exp[8*idx +: 8];
            ee  = (eg == 8'hFF) ? 8'hFF : ~(8'h01 << idx);
            tests++;
            if (bus.seg_tube !== eg || bus.seg_enable !== ee) begin
               failed++;
               $display("FAIL %s cycle %0d digit %0d: seg_tube=%h seg_enable=%h, expected %h %h",
                        name, n, idx, bus.seg_tube, bus.seg_enable, eg, ee);
            end
         end
      end
   endtask

   task automatic check_disp(input string name, input logic [63:0] exp);
      repeat (36) @(negedge clk_tube);
      sample_disp(name, exp, 32);
   endtask

   // Returns at the negedge right after the sampling edge.
   task automatic do_load(input logic [31:0] v, input logic [1:0] m, input logic blz);
      @(negedge clk_tube);
      bus.value    = v;
      bus.mode     = m;
      bus.blank_lz = blz;
      bus.load     = 1'b1;
      @(negedge clk_tube);
      bus.load     = 1'b0;
   endtask

   task automatic busy_cycles(output int cnt);
      cnt = 0;
      while (bus.busy === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk_tube);
      end
   endtask

   initial begin
      int          cnt;
      logic [31:0] v;
      logic [1:0]  m;
      logic        b;
      logic [63:0] e_1234;
      logic [63:0] e_dead;

      e_1234 = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99};
      e_dead = {8'hA1, 8'h86, 8'h88, 8'hA1, 8'h83, 8'h86, 8'h86, 8'h8E};
      vecs[0] = '{32'd1234,      2'b00, 1'b1, e_1234};
      vecs[1] = '{32'd100000000, 2'b00, 1'b1, {8{8'hBF}}};
      vecs[2] = '{32'd99999999,  2'b00, 1'b0, {8{8'h90}}};
      vecs[3] = '{32'hDEADBEEF,  2'b01, 1'b0, e_dead};
      vecs[4] = '{32'hA5,        2'b10, 1'b0,
                  {8'hF9, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hF9}};
      vecs[5] = '{32'd0,         2'b00, 1'b1, {{7{8'hFF}}, 8'hC0}};
      vecs[6] = '{32'h000000F0,  2'b01, 1'b1, {{6{8'hFF}}, 8'h8E, 8'hC0}};
      vecs[7] = '{32'h12345678,  2'b11, 1'b0, {8{8'hFF}}};
      vecs[8] = '{32'd0,         2'b00, 1'b0, {8{8'hC0}}};
`ifdef SEG_SIGNED_EN
      vecs[9] = '{32'hFFFFFFD6,  2'b00, 1'b1, {{5{8'hFF}}, 8'hBF, 8'h99, 8'hA4}};
`else
      vecs[9] = '{32'hFFFFFFD6,  2'b00, 1'b1, {8{8'hBF}}};
`endif

      bus.value = '0; bus.mode = 2'b00; bus.blank_lz = 1'b0; bus.load = 1'b0;
      repeat (3) @(negedge clk_tube);
      chk("reset_busy", 64'(bus.busy), 64'd0);
      chk("reset_seg_tube", 64'(bus.seg_tube), 64'hFF);
      chk("reset_seg_enable", 64'(bus.seg_enable), 64'hFF);
      rst_n = 1'b1;
      sample_disp("reset_blank", {8{8'hFF}}, 40);

      // Table vectors.
      for (int k = 0; k < 10; k++) begin
         do_load(vecs[k].value, vecs[k].mode, vecs[k].blz);
         if (vecs[k].mode == 2'b00) begin
            busy_cycles(cnt);
            chk($sformatf("vec%0d_busy_len", k), 64'(cnt), 64'd33);
         end else begin
            chk($sformatf("vec%0d_no_busy", k), 64'(bus.busy), 64'd0);
         end
         check_disp($sformatf("vec%0d_disp", k), vecs[k].exp);
      end

      // Old buffer stays up during a conversion.
      do_load(32'hDEADBEEF, 2'b01, 1'b0);
      check_disp("hex_before_conv", e_dead);
      do_load(32'd5, 2'b00, 1'b1);
      sample_disp("old_buf_during_conv", e_dead, 28);
      busy_cycles(cnt);
      check_disp("dec5", {{7{8'hFF}}, 8'h92});

      // Loads mid-conversion and on the COMMIT edge are both dropped.
      do_load(32'd1234, 2'b00, 1'b1);
      repeat (4) @(negedge clk_tube);
      bus.value = 32'd77; bus.mode = 2'b00; bus.load = 1'b1;
      @(negedge clk_tube);
      bus.load = 1'b0;
      repeat (27) @(negedge clk_tube);
      chk("busy_before_commit", 64'(bus.busy), 64'd1);
      bus.value = 32'hDEADBEEF; bus.mode = 2'b01; bus.blank_lz = 1'b0; bus.load = 1'b1;
      @(negedge clk_tube);
      bus.load = 1'b0;
      chk("busy_after_commit", 64'(bus.busy), 64'd0);
      check_disp("loads_dropped", e_1234);

      // Asynchronous reset in the middle of a conversion.
      do_load(32'd99999999, 2'b00, 1'b0);
      repeat (10) @(negedge clk_tube);
      #2 rst_n = 1'b0;
      #1;
      chk("midconv_rst_busy", 64'(bus.busy), 64'd0);
      chk("midconv_rst_seg_tube", 64'(bus.seg_tube), 64'hFF);
      chk("midconv_rst_seg_enable", 64'(bus.seg_enable), 64'hFF);
      @(negedge clk_tube);
      rst_n = 1'b1;
      sample_disp("after_rst_blank", {8{8'hFF}}, 45);
      chk("after_rst_idle", 64'(bus.busy), 64'd0);

      // Random loads against the reference model.
      for (int k = 0; k < 24; k++) begin
         v = $urandom;
         case ($urandom_range(0, 4))
            0: v = v & 32'hFF;
            1: v = v % 100000000;
            2: v = v & 32'hFFFF;
            3: v = (v & 32'h1) ? 32'd0 : 32'd100000000 - 32'(v[3:0]);
            default: ;
         endcase
         m = 2'($urandom_range(0, 3));
         b = 1'($urandom_range(0, 1));
         do_load(v, m, b);
         busy_cycles(cnt);
         chk($sformatf("rnd%0d_busy_len", k), 64'(cnt), (m == 2'b00) ? 64'd33 : 64'd0);
         check_disp($sformatf("rnd%0d_v%h_m%0d_b%0d", k, v, m, b), model(v, m, b));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
